uart_tx_buffered: RTL and testbench

Buffered, parametrised UART transmitter. Successor to the fixed 8N1 uart_tx plus hand-sequenced message FSM.
- Upstream logic pushes bytes through a valid/ready interface into an internal FIFO.
- The block serialises them back-to-back with configurable frame format, optional inter-frame gap and a run/pause control.
- Sits between message/packet generators and the TX pin in board top levels.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_tx_buffered.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, serialiser states and the default baud divisor.
package uart_pkg;

  // Clock cycles per bit for a 16 MHz clock at ~115200 baud
  localparam int unsigned BAUD_MULT_16MHZ = 139;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } tx_state_e;

  // Parity bit for a zero-extended data word; zero extension does not change the XOR
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/ready flags and a first-word-fall-through head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [WIDTH-1:0]         rd_data_c,
  input  logic                     rd_en,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_c;
  logic             pop_c;
  logic [CW-1:0]    count_d;

  assign push_c    = wr_valid && wr_ready;
  assign pop_c     = rd_en && !empty;
  assign rd_data_c = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel out
  always_comb begin
    count_d = count + CW'(push_c) - CW'(pop_c);
  end

  // Pointers and flags; ready stays low in reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      wr_ready <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_d;
      empty    <= (count_d == '0);
      wr_ready <= (count_d < CW'(DEPTH));
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed serialiser with configurable frame format and gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_MULT  = BAUD_MULT_16MHZ,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = PARITY_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GAP_BITS   = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_tx_enable,
  output logic                          o_tx_data,
  output logic                          o_tx_active,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_fifo_empty
);

  localparam int unsigned BAUD_W    = $clog2(BAUD_MULT);
  localparam int unsigned BAUD_LAST = BAUD_MULT - 1;
  localparam int unsigned BIT_MAX   = (DATA_BITS > STOP_BITS)
                                      ? ((DATA_BITS > GAP_BITS) ? DATA_BITS : GAP_BITS)
                                      : ((STOP_BITS > GAP_BITS) ? STOP_BITS : GAP_BITS);
  localparam int unsigned CNT_W     = $clog2(BIT_MAX);
  localparam int unsigned DATA_LAST = DATA_BITS - 1;
  localparam int unsigned STOP_LAST = STOP_BITS - 1;
  localparam int unsigned GAP_LAST  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  tx_state_e            state, state_d;
  logic [BAUD_W-1:0]    baud_cnt, baud_d;
  logic [CNT_W-1:0]     bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 done_pend;

  logic [DATA_BITS-1:0] fifo_head_c;
  logic                 fifo_empty;
  logic                 pop_c;
  logic                 frame_end_c;
  logic                 next_frame_c;
  logic                 bit_tick_c;
  logic                 start_ok_c;
  logic                 line_c;
  logic                 active_c;

  // Byte buffer between the producer and the serialiser
  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .wr_data   (i_data),
    .wr_valid  (i_valid),
    .wr_ready  (o_ready),
    .rd_data_c (fifo_head_c),
    .rd_en     (pop_c),
    .count     (o_fifo_count),
    .empty     (fifo_empty)
  );

  assign o_fifo_empty = fifo_empty;

  // Serialiser state, baud counter, bit counter and shift register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
    end
  end

  // Next-state logic; enable is only consulted at frame boundaries
  always_comb begin
    state_d      = state;
    baud_d       = baud_cnt;
    bit_d        = bit_cnt;
    shift_d      = shift_q;
    par_d        = par_q;
    pop_c        = 1'b0;
    frame_end_c  = 1'b0;
    next_frame_c = 1'b0;
    bit_tick_c   = (baud_cnt == BAUD_W'(BAUD_LAST));
    start_ok_c   = !fifo_empty && i_tx_enable;

    if (state != ST_IDLE) baud_d = bit_tick_c ? '0 : baud_cnt + BAUD_W'(1);

    case (state)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start_ok_c) next_frame_c = 1'b1;
      end
      ST_START: begin
        if (bit_tick_c) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick_c) begin
          shift_d = shift_q >> 1;
          if (bit_cnt == CNT_W'(DATA_LAST)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_cnt + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick_c) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick_c) begin
          if (bit_cnt == CNT_W'(STOP_LAST)) begin
            frame_end_c = 1'b1;
            bit_d       = '0;
            if (GAP_BITS != 0) state_d = ST_GAP;
            else               next_frame_c = 1'b1;
          end else begin
            bit_d = bit_cnt + CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (bit_tick_c) begin
          if (bit_cnt == CNT_W'(GAP_LAST)) begin
            bit_d        = '0;
            next_frame_c = 1'b1;
          end else begin
            bit_d = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame boundary: load the FIFO head if allowed, otherwise park in IDLE
    if (next_frame_c) begin
      if (start_ok_c) begin
        pop_c   = 1'b1;
        shift_d = fifo_head_c;
        par_d   = parity_bit(8'(fifo_head_c), PARITY);
        state_d = ST_START;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Line level and activity decoded from the current state
  always_comb begin
    line_c   = 1'b1;
    active_c = 1'b0;
    case (state)
      ST_START:  begin line_c = 1'b0;       active_c = 1'b1; end
      ST_DATA:   begin line_c = shift_q[0]; active_c = 1'b1; end
      ST_PARITY: begin line_c = par_q;      active_c = 1'b1; end
      ST_STOP:   begin line_c = 1'b1;       active_c = 1'b1; end
      default:   begin line_c = 1'b1;       active_c = 1'b0; end
    endcase
  end

  // Registered outputs; done is delayed to line up with the first cycle after the stop bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_data   <= 1'b1;
      o_tx_active <= 1'b0;
      done_pend   <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      o_tx_data   <= line_c;
      o_tx_active <= active_c;
      done_pend   <= frame_end_c;
      o_tx_done   <= done_pend;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three configurations checked against a frame-level model.
module tb_uart_tx_buffered;

  localparam int BAUD = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] din [3];
  logic       vld [3];
  logic       en  [3];

  logic       rdy0, rdy1, rdy2;
  logic       tx0, tx1, tx2;
  logic       act0, act1, act2;
  logic       done0, done1, done2;
  logic       emp0, emp1, emp2;
  logic [4:0] cnt0;
  logic [2:0] cnt1, cnt2;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 8N1, deep FIFO, no gap
  uart_tx_buffered #(.BAUD_MULT(3), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                     .FIFO_DEPTH(16), .GAP_BITS(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din[0]), .i_valid(vld[0]), .o_ready(rdy0),
    .i_tx_enable(en[0]), .o_tx_data(tx0), .o_tx_active(act0), .o_tx_done(done0),
    .o_fifo_count(cnt0), .o_fifo_empty(emp0));

  // 7E2, shallow FIFO, no gap
  uart_tx_buffered #(.BAUD_MULT(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                     .FIFO_DEPTH(4), .GAP_BITS(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din[1][6:0]), .i_valid(vld[1]), .o_ready(rdy1),
    .i_tx_enable(en[1]), .o_tx_data(tx1), .o_tx_active(act1), .o_tx_done(done1),
    .o_fifo_count(cnt1), .o_fifo_empty(emp1));

  // 7O2, shallow FIFO, two-bit gap
  uart_tx_buffered #(.BAUD_MULT(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                     .FIFO_DEPTH(4), .GAP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din[2][6:0]), .i_valid(vld[2]), .o_ready(rdy2),
    .i_tx_enable(en[2]), .o_tx_data(tx2), .o_tx_active(act2), .o_tx_done(done2),
    .o_fifo_count(cnt2), .o_fifo_empty(emp2));

  function automatic logic g_tx(int k);
    case (k) 0: return tx0; 1: return tx1; default: return tx2; endcase
  endfunction
  function automatic logic g_act(int k);
    case (k) 0: return act0; 1: return act1; default: return act2; endcase
  endfunction
  function automatic logic g_done(int k);
    case (k) 0: return done0; 1: return done1; default: return done2; endcase
  endfunction
  function automatic logic g_rdy(int k);
    case (k) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
  endfunction
  function automatic logic g_emp(int k);
    case (k) 0: return emp0; 1: return emp1; default: return emp2; endcase
  endfunction
  function automatic int g_cnt(int k);
    case (k) 0: return int'(cnt0); 1: return int'(cnt1); default: return int'(cnt2); endcase
  endfunction

  // Configuration of each instance
  function automatic int dbits(int k); return (k == 0) ? 8 : 7; endfunction
  function automatic int pmode(int k); return (k == 0) ? 0 : ((k == 1) ? 2 : 1); endfunction
  function automatic int sbits(int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int gbits(int k); return (k == 2) ? 2 : 0; endfunction
  function automatic int flen(int k);
    return (1 + dbits(k) + ((pmode(k) != 0) ? 1 : 0) + sbits(k)) * BAUD;
  endfunction

  // Expected line level for bit slot n of a frame carrying byte b
  function automatic logic exp_line(int k, logic [7:0] b, int n);
    int d = dbits(k);
    int ones = 0;
    for (int i = 0; i < d; i++) ones += int'(b[i]);
    if (n == 0) return 1'b0;
    if (n <= d) return b[n-1];
    if (pmode(k) != 0 && n == d + 1) return (pmode(k) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on the first start-bit cycle; returns on the cycle after the final stop bit
  task automatic check_frame(int k, logic [7:0] b);
    int n = flen(k);
    logic e;
    for (int i = 0; i < n; i++) begin
      e = exp_line(k, b, i / BAUD);
      tests++;
      if (g_tx(k) !== e || g_act(k) !== 1'b1 || (i > 0 && g_done(k) !== 1'b0)) begin
        errors++;
        $display("FAIL frame dut%0d byte=%02h cyc=%0d: got tx=%b act=%b done=%b, want tx=%b act=1 done=0",
                 k, b, i, g_tx(k), g_act(k), g_done(k), e);
      end
      step();
    end
    tests++;
    if (g_done(k) !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse dut%0d byte=%02h: got done=%b, want 1", k, b, g_done(k));
    end
  endtask

  task automatic wait_start(int k, int budget, output logic ok);
    int c = 0;
    while (g_tx(k) !== 1'b0 && c < budget) begin
      step();
      c++;
    end
    ok = (g_tx(k) === 1'b0);
    tests++;
    if (!ok) begin
      errors++;
      $display("FAIL start_timeout dut%0d: no start bit within %0d cycles", k, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'h00; vld[k] = 1'b0; en[k] = 1'b0;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (g_tx(k) !== 1'b1 || g_act(k) !== 1'b0 || g_done(k) !== 1'b0 ||
          g_cnt(k) !== 0 || g_emp(k) !== 1'b1 || g_rdy(k) !== 1'b0) begin
        errors++;
        $display("FAIL reset_values dut%0d: tx=%b act=%b done=%b cnt=%0d emp=%b rdy=%b, want 1 0 0 0 1 0",
                 k, g_tx(k), g_act(k), g_done(k), g_cnt(k), g_emp(k), g_rdy(k));
      end
    end
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (g_rdy(k) !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset dut%0d: rdy=%b, want 1", k, g_rdy(k));
      end
    end
  endtask

  task automatic test_single();
    en[0] = 1'b1;
    din[0] = 8'h48; vld[0] = 1'b1;
    step();                                   // edge N
    vld[0] = 1'b0;
    tests++;
    if (cnt0 !== 5'd1 || emp0 !== 1'b0 || tx0 !== 1'b1) begin
      errors++;
      $display("FAIL single_written: cnt=%0d emp=%b tx=%b, want 1 0 1", cnt0, emp0, tx0);
    end
    step();                                   // edge N+1
    tests++;
    if (tx0 !== 1'b1 || act0 !== 1'b0 || cnt0 !== 5'd0) begin
      errors++;
      $display("FAIL single_latency: tx=%b act=%b cnt=%0d, want 1 0 0", tx0, act0, cnt0);
    end
    step();                                   // edge N+2: start bit
    check_frame(0, 8'h48);
    tests++;
    if (act0 !== 1'b0 || tx0 !== 1'b1 || emp0 !== 1'b1) begin
      errors++;
      $display("FAIL single_after: act=%b tx=%b emp=%b, want 0 1 1", act0, tx0, emp0);
    end
  endtask

  task automatic test_back_to_back();
    string s = "Hello World!\n";
    logic ok;
    en[0] = 1'b1;
    fork
      begin
        for (int i = 0; i < 13; i++) begin
          din[0] = s[i]; vld[0] = 1'b1;
          tests++;
          if (rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL burst_ready idx=%0d: rdy=%b, want 1", i, rdy0);
          end
          step();
        end
        vld[0] = 1'b0;
      end
      begin
        wait_start(0, 10, ok);
        for (int i = 0; i < 13; i++) check_frame(0, s[i]);
      end
    join
    tests++;
    if (emp0 !== 1'b1 || cnt0 !== 5'd0) begin
      errors++;
      $display("FAIL burst_empty: emp=%b cnt=%0d, want 1 0", emp0, cnt0);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] b [6];
    int acc = 0;
    int guard = 0;
    int bad = 0;
    logic ok;
    for (int j = 0; j < 6; j++) b[j] = 8'($urandom) & 8'h7F;
    en[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      din[1] = b[(acc < 6) ? acc : 5]; vld[1] = 1'b1;
      tests++;
      if (rdy1 !== (acc < 4)) begin
        errors++;
        $display("FAIL full_ready cyc=%0d: rdy=%b, want %b", c, rdy1, (acc < 4));
      end
      if (acc < 4) acc++;
      step();
    end
    tests++;
    if (cnt1 !== 3'd4 || tx1 !== 1'b1 || act1 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: cnt=%0d tx=%b act=%b rdy=%b, want 4 1 0 0", cnt1, tx1, act1, rdy1);
    end
    en[1] = 1'b1;
    fork
      begin
        while (acc < 6 && guard < 400) begin
          din[1] = b[acc]; vld[1] = 1'b1;
          if (rdy1 === 1'b1) acc++;
          step();
          guard++;
        end
        vld[1] = 1'b0;
      end
      begin
        wait_start(1, 10, ok);
        for (int j = 0; j < 6; j++) check_frame(1, b[j]);
      end
    join
    tests++;
    if (acc != 6) begin
      errors++;
      $display("FAIL full_accept: accepted=%0d, want 6", acc);
    end
    for (int c = 0; c < 20; c++) begin
      if (tx1 !== 1'b1 || act1 !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0 || emp1 !== 1'b1) begin
      errors++;
      $display("FAIL full_drain: busy cycles=%0d emp=%b, want 0 1", bad, emp1);
    end
  endtask

  task automatic test_parity();
    logic ok;
    en[1] = 1'b1;
    din[1] = 8'h41; vld[1] = 1'b1;
    step();
    vld[1] = 1'b0;
    wait_start(1, 10, ok);
    if (ok) check_frame(1, 8'h41);
    tests++;
    if (act1 !== 1'b0 || tx1 !== 1'b1) begin
      errors++;
      $display("FAIL even_len: act=%b tx=%b after 33 cycles, want 0 1", act1, tx1);
    end
    en[2] = 1'b1;
    din[2] = 8'h41; vld[2] = 1'b1;
    step();
    din[2] = 8'h2A;
    step();
    vld[2] = 1'b0;
    wait_start(2, 10, ok);
    if (ok) check_frame(2, 8'h41);
    for (int g = 0; g < gbits(2) * BAUD; g++) begin
      tests++;
      if (tx2 !== 1'b1 || act2 !== 1'b0 || (g > 0 && done2 !== 1'b0)) begin
        errors++;
        $display("FAIL gap cyc=%0d: tx=%b act=%b done=%b, want 1 0 0", g, tx2, act2, done2);
      end
      step();
    end
    check_frame(2, 8'h2A);
    tests++;
    if (act2 !== 1'b0 || emp2 !== 1'b1) begin
      errors++;
      $display("FAIL odd_after: act=%b emp=%b, want 0 1", act2, emp2);
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] b [3];
    logic ok;
    int bad = 0;
    for (int j = 0; j < 3; j++) b[j] = 8'($urandom);
    en[0] = 1'b1;
    fork
      begin
        for (int j = 0; j < 3; j++) begin
          din[0] = b[j]; vld[0] = 1'b1;
          step();
        end
        vld[0] = 1'b0;
      end
      wait_start(0, 10, ok);
    join
    fork
      check_frame(0, b[0]);
      begin
        repeat (10) step();
        en[0] = 1'b0;
      end
    join
    tests++;
    if (cnt0 !== 5'd2) begin
      errors++;
      $display("FAIL drop_count: cnt=%0d, want 2", cnt0);
    end
    for (int c = 0; c < 12; c++) begin
      step();
      if (tx0 !== 1'b1 || act0 !== 1'b0 || cnt0 !== 5'd2) bad++;
    end
    tests++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_idle: %0d non-idle cycles, want 0", bad);
    end
    en[0] = 1'b1;
    wait_start(0, 10, ok);
    if (ok) begin
      check_frame(0, b[1]);
      check_frame(0, b[2]);
    end
    tests++;
    if (emp0 !== 1'b1) begin
      errors++;
      $display("FAIL drop_resume_empty: emp=%b, want 1", emp0);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int bad = 0;
    en[0] = 1'b1;
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          din[0] = 8'($urandom); vld[0] = 1'b1;
          step();
        end
        vld[0] = 1'b0;
      end
      wait_start(0, 10, ok);
    join
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (tx0 !== 1'b1 || act0 !== 1'b0 || cnt0 !== 5'd0 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: tx=%b act=%b cnt=%0d rdy=%b, want 1 0 0 0", tx0, act0, cnt0, rdy0);
    end
    step();
    step();
    tests++;
    if (done0 !== 1'b0 || tx0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold: done=%b tx=%b, want 0 1", done0, tx0);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (rdy0 !== 1'b1 || cnt0 !== 5'd0 || emp0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: rdy=%b cnt=%0d emp=%b, want 1 0 1", rdy0, cnt0, emp0);
    end
    for (int c = 0; c < 40; c++) begin
      if (tx0 !== 1'b1 || act0 !== 1'b0 || done0 !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d active cycles after reset, want 0", bad);
    end
  endtask

  task automatic test_random(int k, int n);
    logic [7:0] q [$];
    logic [7:0] mask = (k == 0) ? 8'hFF : 8'h7F;
    en[k] = 1'b1;
    fork
      begin
        logic [7:0] b;
        int guard;
        for (int j = 0; j < n; j++) begin
          repeat ($urandom_range(0, 35)) step();
          b = 8'($urandom) & mask;
          din[k] = b; vld[k] = 1'b1;
          guard = 0;
          while (g_rdy(k) !== 1'b1 && guard < 500) begin
            step();
            guard++;
          end
          if (g_rdy(k) === 1'b1) q.push_back(b);
          step();
          vld[k] = 1'b0;
        end
      end
      begin
        logic ok;
        for (int j = 0; j < n; j++) begin
          wait_start(k, 2000, ok);
          if (ok) begin
            tests++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL random_unexpected dut%0d: frame %0d with no queued byte", k, j);
              step();
            end else begin
              check_frame(k, q.pop_front());
            end
          end
        end
      end
    join
    tests++;
    if (q.size() != 0 || g_emp(k) !== 1'b1) begin
      errors++;
      $display("FAIL random_drain dut%0d: model left=%0d emp=%b, want 0 1", k, q.size(), g_emp(k));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_parity();
    test_enable_drop();
    test_reset_mid();
    test_random(0, 16);
    test_random(2, 12);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
